bcd_seg_counter: RTL and testbench

Parametrised N-digit up/down counter with debounced push-button control and registered seven-segment output, the next generation of the board-level switch-to-HEX display path on the DE2 top level. Raw DE2 keys increment, decrement or load the value from the switches; the count is shown on DIGITS active-low HEX displays in decimal or hexadecimal radix, with optional leading-zero blanking. It sits between the `iKEY`/`iSW` pins and the `oHEXn_D` pins inside `DE2_TOP`.

---
 rtl/de2_seg_pkg.sv | 21 ++
 rtl/bcd_seg_counter_if.sv | 28 ++
 rtl/key_debounce.sv | 56 +++++
 rtl/bcd_seg_counter.sv | 127 ++++++++++++
 tb/tb_bcd_seg_counter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/de2_seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// de2_seg_pkg : seven-segment encodings shared by the DE2 display path
// Rev 1.0
// ---------------------------------------------------------------------------
package de2_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 6 = g ... bit 0 = a; entry n encodes hex digit n
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_counter_if : key, switch and display bundle for bcd_seg_counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface bcd_seg_counter_if #(
  parameter int DIGITS = 4
);
  logic                  iKEY_INC;
  logic                  iKEY_DEC;
  logic                  iKEY_LOAD;
  logic [4*DIGITS-1:0]   iLOAD_VAL;
  logic                  iHEX_MODE;
  logic                  iBLANK_LZ;
  logic [7*DIGITS-1:0]   oHEX;
  logic                  oWRAP;

  modport master (
    output iKEY_INC, iKEY_DEC, iKEY_LOAD, iLOAD_VAL, iHEX_MODE, iBLANK_LZ,
    input  oHEX, oWRAP
  );

  modport slave (
    input  iKEY_INC, iKEY_DEC, iKEY_LOAD, iLOAD_VAL, iHEX_MODE, iBLANK_LZ,
    output oHEX, oWRAP
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_debounce : synchronise and debounce an active-low key, pulse on press
// Rev 1.0
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic iCLK_50,
  input  logic iRST_N,
  input  logic iKEY,
  output logic oPRESS
);
  localparam int              CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A differing sample must persist until the counter has reached CNT_MAX
  always_comb begin
    acc_d   = acc_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_MAX) begin
        acc_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= iKEY;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oPRESS = press_q;

endmodule
`default_nettype wire

// File: rtl/bcd_seg_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_counter : N-digit up/down key counter with registered HEX display
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_seg_counter
  import de2_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                    iCLK_50,
  input  logic                    iRST_N,
  bcd_seg_counter_if.slave        bus
);
  logic inc_p, dec_p, load_p;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .iCLK_50(iCLK_50), .iRST_N(iRST_N), .iKEY(bus.iKEY_INC),  .oPRESS(inc_p)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .iCLK_50(iCLK_50), .iRST_N(iRST_N), .iKEY(bus.iKEY_DEC),  .oPRESS(dec_p)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .iCLK_50(iCLK_50), .iRST_N(iRST_N), .iKEY(bus.iKEY_LOAD), .oPRESS(load_p)
  );

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] inc_val, dec_val, load_val;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                wrap_evt_q, wrap_evt_d;
  logic                wrap_q;
  logic                carry, borrow;
  logic [3:0]          max_dig, dig, nib;

  // Digits above 9 in decimal mode are clamped before the ripple, so the
  // result is always a valid decimal count
  always_comb begin
    max_dig  = bus.iHEX_MODE ? 4'hF : 4'h9;
    carry    = 1'b1;
    borrow   = 1'b1;
    inc_val  = '0;
    dec_val  = '0;
    load_val = '0;
    dig      = '0;
    nib      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count_q[4*k +: 4];
      if (!bus.iHEX_MODE && dig > 4'h9) dig = 4'h9;
      if (carry) begin
        if (dig == max_dig) begin
          inc_val[4*k +: 4] = 4'h0;
        end else begin
          inc_val[4*k +: 4] = dig + 4'h1;
          carry             = 1'b0;
        end
      end else begin
        inc_val[4*k +: 4] = dig;
      end
      if (borrow) begin
        if (dig == 4'h0) begin
          dec_val[4*k +: 4] = max_dig;
        end else begin
          dec_val[4*k +: 4] = dig - 4'h1;
          borrow            = 1'b0;
        end
      end else begin
        dec_val[4*k +: 4] = dig;
      end
      nib = bus.iLOAD_VAL[4*k +: 4];
      load_val[4*k +: 4] = (!bus.iHEX_MODE && nib > 4'h9) ? 4'h9 : nib;
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_evt_d = 1'b0;
    if (load_p) begin
      count_d = load_val;
    end else if (inc_p && dec_p) begin
      count_d = count_q;
    end else if (inc_p) begin
      count_d    = inc_val;
      wrap_evt_d = carry;
    end else if (dec_p) begin
      count_d    = dec_val;
      wrap_evt_d = borrow;
    end
  end

  logic       seen_nz;
  logic [3:0] disp_dig;

  // Walk from the most significant digit; blank until a non-zero digit appears
  always_comb begin
    seen_nz  = 1'b0;
    disp_dig = '0;
    hex_d    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      disp_dig = count_q[4*k +: 4];
      if (disp_dig != 4'h0) seen_nz = 1'b1;
      if (bus.iBLANK_LZ && !seen_nz && (k != 0))
        hex_d[7*k +: 7] = SEG_BLANK;
      else
        hex_d[7*k +: 7] = seg_encode(disp_dig);
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      count_q    <= '0;
      wrap_evt_q <= 1'b0;
      wrap_q     <= 1'b0;
      hex_q      <= {DIGITS{SEG_HEX[0]}};
    end else begin
      count_q    <= count_d;
      wrap_evt_q <= wrap_evt_d;
      wrap_q     <= wrap_evt_q;
      hex_q      <= hex_d;
    end
  end

  assign bus.oHEX  = hex_q;
  assign bus.oWRAP = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_seg_counter : directed vector bench for bcd_seg_counter (4 digits)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bcd_seg_counter;
  localparam int DIGITS     = 4;
  localparam int DEB_CYCLES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_seg_counter #(.DIGITS(DIGITS), .DEB_CYCLES(DEB_CYCLES)) dut (
    .iCLK_50 (clk),
    .iRST_N  (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  keys;      // {load, dec, inc}, 1 = pressed
    logic [15:0] load_val;
    logic        hex_mode;
    logic        blank_lz;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
    int          exp_wraps;
  } vec_t;

  vec_t vecs [21];
  int   n_vec = 0;
  int   n_err = 0;
  int   wrap_total = 0;

  always @(negedge clk) if (bus.oWRAP === 1'b1) wrap_total++;

  function automatic logic [6:0] tb_seg(input logic [3:0] n);
    case (n)
      4'h0: tb_seg = 7'b1000000;  4'h1: tb_seg = 7'b1111001;
      4'h2: tb_seg = 7'b0100100;  4'h3: tb_seg = 7'b0110000;
      4'h4: tb_seg = 7'b0011001;  4'h5: tb_seg = 7'b0010010;
      4'h6: tb_seg = 7'b0000010;  4'h7: tb_seg = 7'b1111000;
      4'h8: tb_seg = 7'b0000000;  4'h9: tb_seg = 7'b0010000;
      4'hA: tb_seg = 7'b0001000;  4'hB: tb_seg = 7'b0000011;
      4'hC: tb_seg = 7'b1000110;  4'hD: tb_seg = 7'b0100001;
      4'hE: tb_seg = 7'b0000110;  default: tb_seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] d, input logic [3:0] bl);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[7*k +: 7] = bl[k] ? 7'b1111111 : tb_seg(d[4*k +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hold the selected keys long enough for acceptance, then release and let
  // the release debounce settle.
  task automatic press(input logic [2:0] keys);
    @(negedge clk);
    bus.iKEY_INC  = ~keys[0];
    bus.iKEY_DEC  = ~keys[1];
    bus.iKEY_LOAD = ~keys[2];
    repeat (DEB_CYCLES + 6) @(negedge clk);
    bus.iKEY_INC  = 1'b1;
    bus.iKEY_DEC  = 1'b1;
    bus.iKEY_LOAD = 1'b1;
    repeat (DEB_CYCLES + 8) @(negedge clk);
  endtask

  initial begin
    int w0;
    vecs[0]  = '{3'b100, 16'h0999, 1'b0, 1'b0, 16'h0999, 4'b0000, 0};
    vecs[1]  = '{3'b001, 16'h0000, 1'b0, 1'b0, 16'h1000, 4'b0000, 0};
    vecs[2]  = '{3'b100, 16'h9999, 1'b0, 1'b0, 16'h9999, 4'b0000, 0};
    vecs[3]  = '{3'b001, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1};
    vecs[4]  = '{3'b010, 16'h0000, 1'b0, 1'b0, 16'h9999, 4'b0000, 1};
    vecs[5]  = '{3'b100, 16'h00FF, 1'b1, 1'b0, 16'h00FF, 4'b0000, 0};
    vecs[6]  = '{3'b001, 16'h0000, 1'b1, 1'b0, 16'h0100, 4'b0000, 0};
    vecs[7]  = '{3'b100, 16'h00AB, 1'b1, 1'b0, 16'h00AB, 4'b0000, 0};
    vecs[8]  = '{3'b100, 16'h00AB, 1'b0, 1'b0, 16'h0099, 4'b0000, 0};
    vecs[9]  = '{3'b100, 16'h0042, 1'b0, 1'b1, 16'h0042, 4'b1100, 0};
    vecs[10] = '{3'b100, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b1110, 0};
    vecs[11] = '{3'b100, 16'h0005, 1'b0, 1'b0, 16'h0005, 4'b0000, 0};
    vecs[12] = '{3'b011, 16'h0000, 1'b0, 1'b0, 16'h0005, 4'b0000, 0};
    vecs[13] = '{3'b101, 16'h0321, 1'b0, 1'b0, 16'h0321, 4'b0000, 0};
    vecs[14] = '{3'b010, 16'h0000, 1'b0, 1'b0, 16'h0320, 4'b0000, 0};
    vecs[15] = '{3'b100, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 0};
    vecs[16] = '{3'b010, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b0000, 1};
    vecs[17] = '{3'b001, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1};
    vecs[18] = '{3'b010, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b0000, 1};
    vecs[19] = '{3'b000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 4'b0000, 0};
    vecs[20] = '{3'b010, 16'h0000, 1'b0, 1'b0, 16'h9998, 4'b0000, 0};

    bus.iKEY_INC  = 1'b1;
    bus.iKEY_DEC  = 1'b1;
    bus.iKEY_LOAD = 1'b1;
    bus.iLOAD_VAL = '0;
    bus.iHEX_MODE = 1'b0;
    bus.iBLANK_LZ = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_hex",  32'(bus.oHEX),  32'(exp_hex(16'h0000, 4'b0000)));
    chk("reset_wrap", 32'(bus.oWRAP), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: key low before edge 0 -> pulse at edge 6, display at edge 8
    bus.iKEY_INC = 1'b0;
    @(posedge clk);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) chk("lat_press_e5", 32'(dut.u_deb_inc.oPRESS), 32'd0);
      if (e == 6) chk("lat_press_e6", 32'(dut.u_deb_inc.oPRESS), 32'd1);
      if (e == 7) begin
        chk("lat_press_e7", 32'(dut.u_deb_inc.oPRESS), 32'd0);
        chk("lat_hex_e7",   32'(bus.oHEX), 32'(exp_hex(16'h0000, 4'b0000)));
      end
      if (e == 8) chk("lat_hex_e8", 32'(bus.oHEX), 32'(exp_hex(16'h0001, 4'b0000)));
    end
    @(negedge clk);
    bus.iKEY_INC = 1'b1;
    repeat (DEB_CYCLES + 8) @(negedge clk);

    // Bounce: 2-cycle toggles never reach acceptance
    for (int i = 0; i < 10; i++) begin
      bus.iKEY_INC = i[0];
      repeat (2) @(negedge clk);
    end
    bus.iKEY_INC = 1'b1;
    repeat (DEB_CYCLES + 8) @(negedge clk);
    chk("bounce_hex", 32'(bus.oHEX), 32'(exp_hex(16'h0001, 4'b0000)));

    for (int i = 0; i < 21; i++) begin
      bus.iLOAD_VAL = vecs[i].load_val;
      bus.iHEX_MODE = vecs[i].hex_mode;
      bus.iBLANK_LZ = vecs[i].blank_lz;
      w0 = wrap_total;
      if (vecs[i].keys != 3'b000) press(vecs[i].keys);
      else repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_hex", i), 32'(bus.oHEX),
          32'(exp_hex(vecs[i].exp_digits, vecs[i].exp_blank)));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap_total - w0), 32'(vecs[i].exp_wraps));
    end

    // Reset mid-debounce with the key held: immediate zero display, then
    // exactly one press once reset is released
    bus.iBLANK_LZ = 1'b0;
    bus.iKEY_INC  = 1'b0;
    repeat (DEB_CYCLES) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hex",  32'(bus.oHEX),  32'(exp_hex(16'h0000, 4'b0000)));
    chk("rst_mid_wrap", 32'(bus.oWRAP), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB_CYCLES + 10) @(negedge clk);
    chk("rst_held_hex", 32'(bus.oHEX), 32'(exp_hex(16'h0001, 4'b0000)));
    bus.iKEY_INC = 1'b1;
    repeat (DEB_CYCLES + 8) @(negedge clk);
    chk("rst_release_hex", 32'(bus.oHEX), 32'(exp_hex(16'h0001, 4'b0000)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
